// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the unified-memory arbiter that sits between
// the multicycle RISC-V core (port 0) and the DMA / program loader (port 1).
//   arb_state_t : arbiter FSM states (IDLE -> ACCESS -> RESP)
//   PORT_CPU    : index of the core port
//   PORT_DMA    : index of the DMA / loader port
//   mem_req_t   : one latched memory request (we, addr, wdata)
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                  we;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/rr_pick2.sv
// ---------------------------------------------------------------------------
// rr_pick2
// Purely combinational two-way picker used by mem_arbiter.
// A valid lock keeps the grant with the locking port as long as that port is
// still requesting; otherwise a tie goes to the port that did not own the
// bus last, and a single requester always wins.
// Ports:
//   i_req[1:0]   requests that are eligible this cycle
//   i_lastOwner  port that received the most recent grant
//   i_lockOwner  port currently holding a lock
//   i_lockOk     lock is active and still below its re-grant limit
//   o_grant      winning port index
//   o_valid      at least one eligible request
// ---------------------------------------------------------------------------
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_lastOwner,
    input  logic       i_lockOwner,
    input  logic       i_lockOk,
    output logic       o_grant,
    output logic       o_valid
);

    // Lock overrides round-robin; otherwise alternate on ties.
    always_comb begin
        o_valid = |i_req;
        o_grant = PORT_CPU;
        if (i_lockOk && i_req[i_lockOwner]) begin
            o_grant = i_lockOwner;
        end else if (&i_req) begin
            o_grant = ~i_lastOwner;
        end else if (i_req[PORT_DMA]) begin
            o_grant = PORT_DMA;
        end else begin
            o_grant = PORT_CPU;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one unified instruction/data memory between the core (port 0) and a
// DMA / program loader (port 1). A granted request is latched, presented to
// memory for exactly one cycle, and acknowledged the cycle after, so one
// access completes every two cycles when requests are back to back.
// Parameters:
//   ADDR_W    byte address width
//   DATA_W    data width
//   LOCK_MAX  max consecutive locked re-grants before the other port gets in
// Ports:
//   i_clk              system clock, rising edge
//   i_reset            synchronous, active-low reset
//   i_p_req[1:0]       per-port request, held until acknowledged
//   i_p_we[1:0]        per-port write enable
//   i_p_lock[1:0]      per-port bus-lock request
//   i_p_addr[2]        per-port address
//   i_p_wdata[2]       per-port write data
//   o_p_ack[1:0]       one-cycle completion pulse
//   o_p_rdata          read data, valid with the ack of a read
//   o_mem_we           memory write enable
//   o_mem_addr         memory address
//   o_mem_wdata        memory write data
//   i_mem_rdata        memory read data (combinational read)
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = MEM_ADDR_W,
    parameter int DATA_W   = MEM_DATA_W,
    parameter int LOCK_MAX = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [1:0]        i_p_req,
    input  logic [1:0]        i_p_we,
    input  logic [1:0]        i_p_lock,
    input  logic [ADDR_W-1:0] i_p_addr  [2],
    input  logic [DATA_W-1:0] i_p_wdata [2],
    output logic [1:0]        o_p_ack,
    output logic [DATA_W-1:0] o_p_rdata,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam int             CNT_W      = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] LOCK_LIMIT = CNT_W'(LOCK_MAX);

    arb_state_t        r_state;
    logic              r_owner;
    logic              r_lastOwner;
    logic              r_lock;
    logic [CNT_W-1:0]  r_lockCnt;
    logic              r_memWe;
    logic [ADDR_W-1:0] r_memAddr;
    logic [DATA_W-1:0] r_memWdata;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_ack;

    logic              w_inResp;
    logic [1:0]        w_arbReq;
    logic              w_lockOk;
    logic              w_grant;
    logic              w_valid;

    assign w_inResp = (r_state == RESP);

    // While responding, the owner is still holding the request it is being
    // acked for. That request only counts again if the owner asked for a
    // lock; otherwise it competes from the next arbitration on.
    always_comb begin
        w_arbReq = i_p_req;
        if (w_inResp && !r_lock) begin
            w_arbReq[r_owner] = 1'b0;
        end
    end

    // A lock may only be honoured from RESP, and only until the locked
    // owner has used up its consecutive re-grants. Past the limit the owner
    // still competes, so it keeps the bus if the other port is quiet.
    assign w_lockOk = w_inResp && r_lock && (r_lockCnt < LOCK_LIMIT);

    rr_pick2 u_pick (
        .i_req       (w_arbReq),
        .i_lastOwner (r_lastOwner),
        .i_lockOwner (r_owner),
        .i_lockOk    (w_lockOk),
        .o_grant     (w_grant),
        .o_valid     (w_valid)
    );

    // Arbiter FSM with registered memory-side and port-side outputs.
    // IDLE and RESP share the arbitration path, which is what makes
    // back-to-back accesses possible directly out of RESP. The lock counter
    // only advances on a locked re-grant to the same owner and clears on
    // every other latch.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state     <= IDLE;
            r_owner     <= PORT_CPU;
            r_lastOwner <= PORT_DMA;
            r_lock      <= 1'b0;
            r_lockCnt   <= '0;
            r_memWe     <= 1'b0;
            r_memAddr   <= '0;
            r_memWdata  <= '0;
            r_rdata     <= '0;
            r_ack       <= '0;
        end else begin
            unique case (r_state)
                IDLE, RESP: begin
                    r_ack <= '0;
                    if (w_valid) begin
                        if (w_inResp && r_lock && (w_grant == r_owner)) begin
                            if (r_lockCnt != LOCK_LIMIT) begin
                                r_lockCnt <= r_lockCnt + CNT_W'(1);
                            end
                        end else begin
                            r_lockCnt <= '0;
                        end
                        r_owner     <= w_grant;
                        r_lastOwner <= w_grant;
                        r_lock      <= i_p_lock[w_grant];
                        r_memWe     <= i_p_we[w_grant];
                        r_memAddr   <= i_p_addr[w_grant];
                        r_memWdata  <= i_p_wdata[w_grant];
                        r_state     <= ACCESS;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                ACCESS: begin
                    r_rdata <= i_mem_rdata;
                    r_memWe <= 1'b0;
                    r_ack   <= (r_owner == PORT_DMA) ? 2'b10 : 2'b01;
                    r_state <= RESP;
                end
                default: begin
                    r_memWe <= 1'b0;
                    r_ack   <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_p_ack     = r_ack;
    assign o_p_rdata   = r_rdata;
    assign o_mem_we    = r_memWe;
    assign o_mem_addr  = r_memAddr;
    assign o_mem_wdata = r_memWdata;

endmodule
